// File: rtl/rv_pkg.sv
// Shared RV32I decode types: opcodes, ALU/immediate selectors, decoded fields and the
// instruction decode function used by the decode stage.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd, AluPassB
  } alu_op_e;

  typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ} imm_sel_e;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       rd_we;
    logic       illegal;
    imm_sel_e   imm_sel;
    alu_op_e    alu_op;
  } decoded_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            rd_we;
    logic            illegal;
    alu_op_e         alu_op;
  } entry_t;

  // alt selects SUB/SRA (funct7[5]); callers mask it for OP-IMM where only SRAI uses it.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    unique case (f3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  function automatic decoded_t decode(input logic [31:0] instr);
    decoded_t   d;
    logic       writes;
    logic [2:0] f3;
    f3         = instr[14:12];
    writes     = 1'b0;
    d          = '0;
    d.rd       = instr[11:7];
    d.rs1      = instr[19:15];
    d.rs2      = instr[24:20];
    d.imm_sel  = ImmNone;
    d.alu_op   = AluAdd;
    unique case (instr[6:0])
      OpLui: begin
        d.imm_sel = ImmU;
        d.alu_op  = AluPassB;
        writes    = 1'b1;
      end
      OpAuipc: begin
        d.imm_sel = ImmU;
        writes    = 1'b1;
      end
      OpJal: begin
        d.imm_sel = ImmJ;
        writes    = 1'b1;
      end
      OpJalr, OpLoad: begin
        d.imm_sel  = ImmI;
        d.uses_rs1 = 1'b1;
        writes     = 1'b1;
      end
      OpBranch: begin
        d.imm_sel  = ImmB;
        d.uses_rs1 = 1'b1;
        d.uses_rs2 = 1'b1;
        d.alu_op   = (f3[2:1] == 2'b10) ? AluSlt : (f3[2:1] == 2'b11) ? AluSltu : AluSub;
      end
      OpStore: begin
        d.imm_sel  = ImmS;
        d.uses_rs1 = 1'b1;
        d.uses_rs2 = 1'b1;
      end
      OpImm: begin
        d.imm_sel  = ImmI;
        d.uses_rs1 = 1'b1;
        d.alu_op   = alu_from_f3(f3, instr[30] & (f3 == 3'b101));
        writes     = 1'b1;
      end
      OpReg: begin
        d.uses_rs1 = 1'b1;
        d.uses_rs2 = 1'b1;
        d.alu_op   = alu_from_f3(f3, instr[30]);
        writes     = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    d.rd_we = writes & (d.rd != 5'd0);
    return d;
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// RV32I immediate generator: extracts and sign-extends the I/S/B/U/J immediate.
module rv_imm_gen
  import rv_pkg::*;
(
  input  logic [31:7]     instr_i,
  input  imm_sel_e        imm_sel_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    unique case (imm_sel_i)
      ImmI: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      ImmS: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      ImmB: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                     instr_i[11:8], 1'b0};
      ImmU: imm32 = {instr_i[31:12], 12'b0};
      ImmJ: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                     instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/instr_decode.sv
// RV32I decode stage: valid/ready intake, busy-bit hazard scoreboard, register_file read
// port drive and a one-entry decoded pipeline register towards execute.
module instr_decode
  import rv_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_fetch_valid,
  output logic            o_fetch_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_rs1_out,
  output logic            o_rs2_out,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic            o_ex_valid,
  input  logic            i_ex_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [4:0]      o_rd,
  output logic            o_rd_we,
  output logic [XLEN-1:0] o_imm,
  output logic [3:0]      o_alu_op,
  output logic            o_illegal,
  input  logic            i_wb_valid,
  input  logic [4:0]      i_wb_rd,
  input  logic            i_flush
);

  decoded_t        dec;
  logic [XLEN-1:0] imm;
  logic            hazard;
  logic            accept;

  logic [31:0] busy_q, busy_d;
  logic        ex_valid_q, ex_valid_d;
  entry_t      ent_q, ent_d;

  assign dec = decode(i_instr);

  rv_imm_gen u_imm_gen (
    .instr_i  (i_instr[31:7]),
    .imm_sel_i(dec.imm_sel),
    .imm_o    (imm)
  );

  // Registered busy bits only: a same-cycle writeback does not release the stall.
  assign hazard = (dec.uses_rs1 & (dec.rs1 != 5'd0) & busy_q[dec.rs1])
                | (dec.uses_rs2 & (dec.rs2 != 5'd0) & busy_q[dec.rs2])
                | (dec.rd_we & busy_q[dec.rd]);

  assign o_fetch_ready = i_reset_n & ~i_flush & (~ex_valid_q | i_ex_ready) & ~hazard;
  assign accept        = i_fetch_valid & o_fetch_ready;

  // Present the incoming sources on accept so the register_file's registered read lines
  // up with o_ex_valid; otherwise keep the held entry's sources steady.
  always_comb begin
    if (accept) begin
      o_rs1_out = dec.uses_rs1;
      o_rs2_out = dec.uses_rs2;
      o_rs1     = dec.rs1;
      o_rs2     = dec.rs2;
    end else begin
      o_rs1_out = ent_q.uses_rs1;
      o_rs2_out = ent_q.uses_rs2;
      o_rs1     = ent_q.rs1;
      o_rs2     = ent_q.rs2;
    end
  end

  always_comb begin
    ent_d      = ent_q;
    ex_valid_d = ex_valid_q;
    busy_d     = busy_q;
    if (accept) begin
      ent_d.pc       = i_pc;
      ent_d.imm      = imm;
      ent_d.rd       = dec.rd;
      ent_d.rs1      = dec.rs1;
      ent_d.rs2      = dec.rs2;
      ent_d.uses_rs1 = dec.uses_rs1;
      ent_d.uses_rs2 = dec.uses_rs2;
      ent_d.rd_we    = dec.rd_we;
      ent_d.illegal  = dec.illegal;
      ent_d.alu_op   = dec.alu_op;
      ex_valid_d     = 1'b1;
    end else if (i_ex_ready) begin
      ex_valid_d = 1'b0;
    end
    if (i_wb_valid) begin
      busy_d[i_wb_rd] = 1'b0;
    end
    // Applied after the writeback clear so a younger writer of the same rd stays busy.
    if (accept && dec.rd_we) begin
      busy_d[dec.rd] = 1'b1;
    end
    if (i_flush) begin
      ex_valid_d = 1'b0;
      busy_d     = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      ex_valid_q <= 1'b0;
      busy_q     <= '0;
      ent_q      <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      busy_q     <= busy_d;
      ent_q      <= ent_d;
    end
  end

  assign o_ex_valid = ex_valid_q;
  assign o_pc       = ent_q.pc;
  assign o_rd       = ent_q.rd;
  assign o_rd_we    = ent_q.rd_we;
  assign o_imm      = ent_q.imm;
  assign o_alu_op   = ent_q.alu_op;
  assign o_illegal  = ent_q.illegal;

endmodule

// File: tb/tb_instr_decode.sv
// Bench for instr_decode: directed hazard/flush/reset sequences, a decode vector table and
// a randomized run against a scoreboard model built from the RV32I encoding rules.
module tb_instr_decode;
  import rv_pkg::*;

  logic            i_clk = 1'b0;
  logic            i_reset_n;
  logic            i_fetch_valid;
  logic            o_fetch_ready;
  logic [31:0]     i_instr;
  logic [XLEN-1:0] i_pc;
  logic            o_rs1_out, o_rs2_out;
  logic [4:0]      o_rs1, o_rs2;
  logic            o_ex_valid;
  logic            i_ex_ready;
  logic [XLEN-1:0] o_pc;
  logic [4:0]      o_rd;
  logic            o_rd_we;
  logic [XLEN-1:0] o_imm;
  logic [3:0]      o_alu_op;
  logic            o_illegal;
  logic            i_wb_valid;
  logic [4:0]      i_wb_rd;
  logic            i_flush;

  always #5 i_clk = ~i_clk;

  instr_decode dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_fetch_valid(i_fetch_valid),
    .o_fetch_ready(o_fetch_ready), .i_instr(i_instr), .i_pc(i_pc),
    .o_rs1_out(o_rs1_out), .o_rs2_out(o_rs2_out), .o_rs1(o_rs1), .o_rs2(o_rs2),
    .o_ex_valid(o_ex_valid), .i_ex_ready(i_ex_ready), .o_pc(o_pc), .o_rd(o_rd),
    .o_rd_we(o_rd_we), .o_imm(o_imm), .o_alu_op(o_alu_op), .o_illegal(o_illegal),
    .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd), .i_flush(i_flush)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Reference decode from the RV32I encoding tables.
  typedef struct {
    bit          u1, u2, wr, ill, imm_ok;
    logic [31:0] imm;
  } mdec_t;

  function automatic mdec_t mdec(input logic [31:0] ins);
    mdec_t m;
    int    sx;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    sx    = $signed(ins);
    imm_i = 32'(sx >>> 20);
    imm_s = 32'((sx >>> 20) & ~31) | 32'(ins[11:7]);
    imm_b = (32'(sx >>> 19) & 32'hFFFFF000) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5)
          | (32'(ins[11:8]) << 1);
    imm_u = ins & 32'hFFFFF000;
    imm_j = (32'(sx >>> 11) & 32'hFFF00000) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11)
          | (32'(ins[30:21]) << 1);
    m = '{default: 0};
    case (ins[6:0])
      7'h37, 7'h17: begin m.wr = 1; m.imm = imm_u; m.imm_ok = 1; end
      7'h6F:        begin m.wr = 1; m.imm = imm_j; m.imm_ok = 1; end
      7'h67, 7'h03, 7'h13: begin m.u1 = 1; m.wr = 1; m.imm = imm_i; m.imm_ok = 1; end
      7'h63:        begin m.u1 = 1; m.u2 = 1; m.imm = imm_b; m.imm_ok = 1; end
      7'h23:        begin m.u1 = 1; m.u2 = 1; m.imm = imm_s; m.imm_ok = 1; end
      7'h33:        begin m.u1 = 1; m.u2 = 1; m.wr = 1; end
      default:      m.ill = 1;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops[9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 8)];
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  typedef struct {
    logic [31:0] instr, pc, imm;
    logic [4:0]  rd;
    bit          rd_chk, rd_we, imm_chk, ill, r1o, r2o;
  } vec_t;

  vec_t vecs[11];

  // Random-phase model state.
  bit          busy_m[32];
  bit          mvalid, h_known, h_u1, h_u2, h_we, h_ill, h_immok, h_wr;
  logic [4:0]  h_rs1, h_rs2, h_rd;
  logic [31:0] h_imm, h_pc;

  initial begin
    vecs[0]  = '{instr: 32'h00500093, pc: 32'h1000, imm: 32'd5, rd: 5'd1,
                 rd_chk: 1, rd_we: 1, imm_chk: 1, ill: 0, r1o: 1, r2o: 0};
    vecs[1]  = '{instr: 32'h00108133, pc: 32'h1004, imm: 32'd0, rd: 5'd2,
                 rd_chk: 1, rd_we: 1, imm_chk: 0, ill: 0, r1o: 1, r2o: 1};
    vecs[2]  = '{instr: 32'h0020A423, pc: 32'h1008, imm: 32'd8, rd: 5'd0,
                 rd_chk: 0, rd_we: 0, imm_chk: 1, ill: 0, r1o: 1, r2o: 1};
    vecs[3]  = '{instr: 32'h123452B7, pc: 32'h100C, imm: 32'h12345000, rd: 5'd5,
                 rd_chk: 1, rd_we: 1, imm_chk: 1, ill: 0, r1o: 0, r2o: 0};
    vecs[4]  = '{instr: 32'hFFFFFFFF, pc: 32'h1010, imm: 32'd0, rd: 5'd0,
                 rd_chk: 0, rd_we: 0, imm_chk: 0, ill: 1, r1o: 0, r2o: 0};
    vecs[5]  = '{instr: 32'hFE208EE3, pc: 32'h1014, imm: 32'hFFFFFFFC, rd: 5'd0,
                 rd_chk: 0, rd_we: 0, imm_chk: 1, ill: 0, r1o: 1, r2o: 1};
    vecs[6]  = '{instr: 32'h008000EF, pc: 32'h1018, imm: 32'd8, rd: 5'd1,
                 rd_chk: 1, rd_we: 1, imm_chk: 1, ill: 0, r1o: 0, r2o: 0};
    vecs[7]  = '{instr: 32'hFFF22183, pc: 32'h101C, imm: 32'hFFFFFFFF, rd: 5'd3,
                 rd_chk: 1, rd_we: 1, imm_chk: 1, ill: 0, r1o: 1, r2o: 0};
    vecs[8]  = '{instr: 32'h00000013, pc: 32'h1020, imm: 32'd0, rd: 5'd0,
                 rd_chk: 1, rd_we: 0, imm_chk: 1, ill: 0, r1o: 1, r2o: 0};
    vecs[9]  = '{instr: 32'hFFFFF397, pc: 32'h1024, imm: 32'hFFFFF000, rd: 5'd7,
                 rd_chk: 1, rd_we: 1, imm_chk: 1, ill: 0, r1o: 0, r2o: 0};
    vecs[10] = '{instr: 32'h00008067, pc: 32'h1028, imm: 32'd0, rd: 5'd0,
                 rd_chk: 1, rd_we: 0, imm_chk: 1, ill: 0, r1o: 1, r2o: 0};

    i_reset_n = 1'b0; i_fetch_valid = 1'b1; i_instr = 32'h00500093; i_pc = '0;
    i_ex_ready = 1'b1; i_wb_valid = 1'b0; i_wb_rd = '0; i_flush = 1'b0;

    // Reset held low for two edges; ready must stay low throughout.
    #1 chk("rst_ready_low0", o_fetch_ready, 0);
    step(); step();
    chk("rst_ready_low1", o_fetch_ready, 0);
    i_reset_n = 1'b1; i_fetch_valid = 1'b0;
    #1;
    chk("rst_ex_valid", o_ex_valid, 0);
    chk("rst_ready", o_fetch_ready, 1);
    chk("rst_rd", o_rd, 0);
    chk("rst_rd_we", o_rd_we, 0);
    chk("rst_imm", o_imm, 0);
    chk("rst_pc", o_pc, 0);
    chk("rst_alu_op", o_alu_op, 0);
    chk("rst_illegal", o_illegal, 0);

    // addi x1,x0,5
    i_fetch_valid = 1'b1; i_instr = 32'h00500093; i_pc = 32'h100;
    #1;
    chk("addi_ready", o_fetch_ready, 1);
    chk("addi_rs1_out", o_rs1_out, 1);
    chk("addi_rs1", o_rs1, 0);
    chk("addi_rs2_out", o_rs2_out, 0);
    step();
    chk("addi_valid", o_ex_valid, 1);
    chk("addi_rd", o_rd, 1);
    chk("addi_rd_we", o_rd_we, 1);
    chk("addi_imm", o_imm, 5);
    chk("addi_pc", o_pc, 32'h100);

    // add x2,x1,x1 stalls on busy x1 until one cycle after writeback
    i_instr = 32'h00108133; i_pc = 32'h104;
    #1 chk("raw_stall0", o_fetch_ready, 0);
    step();
    chk("raw_drained", o_ex_valid, 0);
    chk("raw_stall1", o_fetch_ready, 0);
    i_wb_valid = 1'b1; i_wb_rd = 5'd1;
    #1 chk("raw_no_wb_bypass", o_fetch_ready, 0);
    step();
    i_wb_valid = 1'b0;
    #1;
    chk("raw_release", o_fetch_ready, 1);
    chk("raw_rs1", o_rs1, 1);
    chk("raw_rs2", o_rs2, 1);
    step();
    i_fetch_valid = 1'b0;
    chk("add_valid", o_ex_valid, 1);
    chk("add_rd", o_rd, 2);

    // retire x2, then sw x2,8(x1) held under backpressure
    i_wb_valid = 1'b1; i_wb_rd = 5'd2;
    step();
    i_wb_valid = 1'b0;
    i_fetch_valid = 1'b1; i_instr = 32'h0020A423; i_pc = 32'h108;
    #1 chk("sw_ready", o_fetch_ready, 1);
    step();
    i_instr = 32'h123452B7; i_pc = 32'h10C; i_ex_ready = 1'b0;
    chk("sw_imm", o_imm, 8);
    chk("sw_rd_we", o_rd_we, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("hold%0d_ready", k), o_fetch_ready, 0);
      chk($sformatf("hold%0d_valid", k), o_ex_valid, 1);
      chk($sformatf("hold%0d_rs1", k), o_rs1, 1);
      chk($sformatf("hold%0d_rs2", k), o_rs2, 2);
      chk($sformatf("hold%0d_imm", k), o_imm, 8);
      chk($sformatf("hold%0d_pc", k), o_pc, 32'h108);
      step();
    end
    i_ex_ready = 1'b1;
    #1 chk("lui_ready", o_fetch_ready, 1);
    step();
    chk("lui_imm", o_imm, 32'h12345000);
    chk("lui_rd", o_rd, 5);
    chk("lui_rd_we", o_rd_we, 1);

    // add x7,x5,x5 with flush: no accept, entry squashed, scoreboard cleared
    i_instr = 32'h005283B3; i_pc = 32'h110; i_flush = 1'b1;
    #1 chk("flush_ready", o_fetch_ready, 0);
    step();
    i_flush = 1'b0;
    chk("flush_valid", o_ex_valid, 0);
    #1 chk("flush_clears_busy", o_fetch_ready, 1);
    step();
    i_fetch_valid = 1'b0;
    chk("post_flush_rd", o_rd, 7);

    // same-edge writeback clear and accept set of x3: set wins
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    i_fetch_valid = 1'b1; i_instr = 32'h00100193; i_wb_valid = 1'b1; i_wb_rd = 5'd3;
    #1 chk("setwin_accept", o_fetch_ready, 1);
    step();
    i_wb_valid = 1'b0; i_instr = 32'h00018233;
    #1 chk("setwin_busy", o_fetch_ready, 0);
    i_fetch_valid = 1'b0; i_flush = 1'b1;
    step();
    i_flush = 1'b0;

    // illegal word: passed through, sets no busy bit
    i_fetch_valid = 1'b1; i_instr = 32'hFFFFFFFF; i_pc = 32'h200;
    #1;
    chk("ill_ready", o_fetch_ready, 1);
    chk("ill_rs1_out", o_rs1_out, 0);
    chk("ill_rs2_out", o_rs2_out, 0);
    step();
    chk("ill_flag", o_illegal, 1);
    chk("ill_rd_we", o_rd_we, 0);
    chk("ill_valid", o_ex_valid, 1);
    i_instr = 32'h01FF8433;
    #1 chk("ill_no_busy", o_fetch_ready, 1);
    step();
    i_fetch_valid = 1'b0; i_ex_ready = 1'b0;
    step();
    chk("hold_before_rst", o_ex_valid, 1);
    i_reset_n = 1'b0;
    #1 chk("rst_mid_ready", o_fetch_ready, 0);
    step();
    i_reset_n = 1'b1; i_ex_ready = 1'b1;
    chk("rst_mid_valid", o_ex_valid, 0);
    chk("rst_mid_rd", o_rd, 0);
    i_fetch_valid = 1'b1; i_instr = 32'h000404B3;
    #1 chk("rst_mid_busy", o_fetch_ready, 1);
    step();
    i_fetch_valid = 1'b0;

    // Decode vector table, each from a flushed state
    for (int i = 0; i < 11; i++) begin
      i_flush = 1'b1; i_fetch_valid = 1'b0;
      step();
      i_flush = 1'b0; i_fetch_valid = 1'b1; i_ex_ready = 1'b1;
      i_instr = vecs[i].instr; i_pc = vecs[i].pc;
      #1;
      chk($sformatf("vec%0d_ready", i), o_fetch_ready, 1);
      chk($sformatf("vec%0d_rs1_out", i), o_rs1_out, vecs[i].r1o);
      chk($sformatf("vec%0d_rs2_out", i), o_rs2_out, vecs[i].r2o);
      if (vecs[i].r1o) chk($sformatf("vec%0d_rs1", i), o_rs1, vecs[i].instr[19:15]);
      if (vecs[i].r2o) chk($sformatf("vec%0d_rs2", i), o_rs2, vecs[i].instr[24:20]);
      step();
      i_fetch_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), o_ex_valid, 1);
      chk($sformatf("vec%0d_pc", i), o_pc, vecs[i].pc);
      chk($sformatf("vec%0d_rd_we", i), o_rd_we, vecs[i].rd_we);
      chk($sformatf("vec%0d_illegal", i), o_illegal, vecs[i].ill);
      if (vecs[i].imm_chk) chk($sformatf("vec%0d_imm", i), o_imm, vecs[i].imm);
      if (vecs[i].rd_chk) chk($sformatf("vec%0d_rd", i), o_rd, vecs[i].rd);
    end

    // Randomized run against the scoreboard model
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    mvalid = 0; h_known = 0;
    foreach (busy_m[r]) busy_m[r] = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      mdec_t      m;
      bit         hz, exp_ready, acc, we;
      logic [4:0] rs1f, rs2f, rdf;
      i_fetch_valid = ($urandom_range(0, 3) != 0);
      i_instr       = rand_instr();
      i_pc          = $urandom & 32'hFFFFFFFC;
      i_ex_ready    = ($urandom_range(0, 3) != 0);
      i_wb_valid    = ($urandom_range(0, 2) == 0);
      i_wb_rd       = 5'($urandom_range(0, 7));
      i_flush       = ($urandom_range(0, 29) == 0);
      #1;
      m    = mdec(i_instr);
      rs1f = i_instr[19:15];
      rs2f = i_instr[24:20];
      rdf  = i_instr[11:7];
      we   = m.wr && (rdf != 0);
      hz   = (m.u1 && rs1f != 0 && busy_m[rs1f]) || (m.u2 && rs2f != 0 && busy_m[rs2f])
          || (we && busy_m[rdf]);
      exp_ready = !i_flush && (!mvalid || i_ex_ready) && !hz;
      chk("rnd_ready", o_fetch_ready, exp_ready);
      acc = i_fetch_valid && exp_ready;
      if (acc) begin
        chk("rnd_rs1_out", o_rs1_out, m.u1);
        chk("rnd_rs2_out", o_rs2_out, m.u2);
        if (m.u1) chk("rnd_rs1", o_rs1, rs1f);
        if (m.u2) chk("rnd_rs2", o_rs2, rs2f);
      end else if (h_known) begin
        chk("rnd_hold_rs1_out", o_rs1_out, h_u1);
        chk("rnd_hold_rs2_out", o_rs2_out, h_u2);
        if (h_u1) chk("rnd_hold_rs1", o_rs1, h_rs1);
        if (h_u2) chk("rnd_hold_rs2", o_rs2, h_rs2);
      end
      if (i_flush) begin
        mvalid = 0;
        foreach (busy_m[r]) busy_m[r] = 0;
      end else begin
        if (i_wb_valid && i_wb_rd != 0) busy_m[i_wb_rd] = 0;
        if (acc) begin
          mvalid = 1; h_known = 1;
          h_u1 = m.u1; h_u2 = m.u2; h_rs1 = rs1f; h_rs2 = rs2f; h_rd = rdf;
          h_we = we; h_wr = m.wr; h_ill = m.ill; h_imm = m.imm; h_immok = m.imm_ok;
          h_pc = i_pc;
          if (we) busy_m[rdf] = 1;
        end else if (i_ex_ready) begin
          mvalid = 0;
        end
      end
      step();
      chk("rnd_ex_valid", o_ex_valid, mvalid);
      if (mvalid) begin
        chk("rnd_pc", o_pc, h_pc);
        chk("rnd_rd_we", o_rd_we, h_we);
        chk("rnd_illegal", o_illegal, h_ill);
        if (h_immok) chk("rnd_imm", o_imm, h_imm);
        if (h_wr) chk("rnd_rd", o_rd, h_rd);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
